// File: rtl/flash_responder.sv
// flash_responder: behavioural responder for a 16-bit parallel NOR-flash style bus.
// It models a small word array with a status register, word programming (bits can
// only be cleared), and block erase with a busy period. It also supports a
// synchronous abort through rp.
//
// Ports
//   clk        : sole clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   flash_addr : byte address; word address = flash_addr[MEM_AW:1], other bits alias
//   flash_data : shared 16-bit bus; driven with the read register when ce and oe are low
//   flash_ctl  : {byte, ce, ce1, ce2, oe, rp, vpen, we}; ce/oe/we/rp active-low
//   busy       : high exactly while a program or erase is executing
module flash_responder #(
    parameter int MEM_AW      = 8,
    parameter int BLK_AW      = 5,
    parameter int PROG_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [22:0] flash_addr,
    inout  wire  [15:0] flash_data,
    input  logic [7:0]  flash_ctl,
    output logic        busy
);
    localparam int PCW = $clog2(PROG_CYCLES + 1);
    localparam logic [PCW-1:0]    PCNT_LOAD = PCW'(PROG_CYCLES);
    localparam logic [PCW-1:0]    PCNT_ONE  = PCW'(1);
    localparam logic [BLK_AW-1:0] ECNT_ONE  = BLK_AW'(1);
    localparam logic [BLK_AW-1:0] ECNT_LAST = {BLK_AW{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_PROG_SETUP  = 3'd1,
        ST_PROG_BUSY   = 3'd2,
        ST_ERASE_SETUP = 3'd3,
        ST_ERASE_BUSY  = 3'd4
    } state_t;

    // Control field decode
    logic ce_s, oe_s, rp_s, vpen_s, we_s;
    assign ce_s   = flash_ctl[6];
    assign oe_s   = flash_ctl[3];
    assign rp_s   = flash_ctl[2];
    assign vpen_s = flash_ctl[1];
    assign we_s   = flash_ctl[0];

    // byte, ce1, ce2 and the aliased/ignored address bits have no function here
    logic unused_s;
    assign unused_s = ^{flash_addr[22:MEM_AW+1], flash_addr[0], flash_ctl[7], flash_ctl[5:4]};

    state_t              state_r, state_nxt_s;
    logic                rmode_r, rmode_nxt_s;   // 1 = status read mode, 0 = array
    logic [7:0]          sr_r, sr_nxt_s;
    logic [PCW-1:0]      pcnt_r, pcnt_nxt_s;
    logic [BLK_AW-1:0]   ecnt_r, ecnt_nxt_s;
    logic [MEM_AW-1:0]   addr_r, addr_nxt_s;
    logic [15:0]         data_r, data_nxt_s;
    logic                we_q_r;
    logic [15:0]         rd_q_r;
    logic                busy_r;
    logic [15:0]         mem_r [0:(1<<MEM_AW)-1];

    logic                sel_s, wr_s;
    logic [7:0]          cmd_s;
    logic [MEM_AW-1:0]   waddr_s;
    logic                mem_we_s;
    logic [MEM_AW-1:0]   mem_wa_s;
    logic [15:0]         mem_wd_s;

    assign sel_s   = ~ce_s;
    // A command write is the rising edge of we seen through the registered copy
    assign wr_s    = sel_s & ~we_q_r & we_s;
    assign cmd_s   = flash_data[7:0];
    assign waddr_s = flash_addr[MEM_AW:1];

    assign flash_data = (sel_s && !oe_s) ? rd_q_r : 16'hzzzz;
    assign busy       = busy_r;

    // Next-state, status and memory-write decode
    always_comb begin
        state_nxt_s = state_r;
        rmode_nxt_s = rmode_r;
        sr_nxt_s    = sr_r;
        pcnt_nxt_s  = pcnt_r;
        ecnt_nxt_s  = ecnt_r;
        addr_nxt_s  = addr_r;
        data_nxt_s  = data_r;
        mem_we_s    = 1'b0;
        mem_wa_s    = addr_r;
        mem_wd_s    = data_r;
        if (!rp_s) begin
            // Abort: nothing further is written, already-erased words stay erased
            state_nxt_s = ST_IDLE;
            rmode_nxt_s = 1'b0;
            sr_nxt_s    = 8'h80;
            pcnt_nxt_s  = {PCW{1'b0}};
            ecnt_nxt_s  = {BLK_AW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (wr_s) begin
                        case (cmd_s)
                            8'hFF:        rmode_nxt_s   = 1'b0;
                            8'h70:        rmode_nxt_s   = 1'b1;
                            8'h50:        sr_nxt_s[5:3] = 3'b000;
                            8'h40, 8'h10: state_nxt_s   = ST_PROG_SETUP;
                            8'h20:        state_nxt_s   = ST_ERASE_SETUP;
                            default:      state_nxt_s   = ST_IDLE;
                        endcase
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_PROG_SETUP: begin
                    if (wr_s) begin
                        addr_nxt_s = waddr_s;
                        data_nxt_s = flash_data;
                        if (!vpen_s) begin
                            sr_nxt_s[4] = 1'b1;
                            sr_nxt_s[3] = 1'b1;
                            state_nxt_s = ST_IDLE;
                        end else begin
                            sr_nxt_s[7] = 1'b0;
                            rmode_nxt_s = 1'b1;
                            pcnt_nxt_s  = PCNT_LOAD;
                            state_nxt_s = ST_PROG_BUSY;
                        end
                    end else begin
                        state_nxt_s = ST_PROG_SETUP;
                    end
                end
                ST_PROG_BUSY: begin
                    if (pcnt_r <= PCNT_ONE) begin
                        // Last busy cycle: programming can only clear bits
                        pcnt_nxt_s  = {PCW{1'b0}};
                        mem_we_s    = 1'b1;
                        mem_wd_s    = mem_r[addr_r] & data_r;
                        sr_nxt_s[7] = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        pcnt_nxt_s  = pcnt_r - PCNT_ONE;
                    end
                end
                ST_ERASE_SETUP: begin
                    if (wr_s) begin
                        if ((cmd_s == 8'hD0) && vpen_s) begin
                            addr_nxt_s  = {waddr_s[MEM_AW-1:BLK_AW], {BLK_AW{1'b0}}};
                            ecnt_nxt_s  = {BLK_AW{1'b0}};
                            sr_nxt_s[7] = 1'b0;
                            rmode_nxt_s = 1'b1;
                            state_nxt_s = ST_ERASE_BUSY;
                        end else if (cmd_s != 8'hD0) begin
                            sr_nxt_s[5] = 1'b1;
                            sr_nxt_s[4] = 1'b1;
                            state_nxt_s = ST_IDLE;
                        end else begin
                            sr_nxt_s[5] = 1'b1;
                            sr_nxt_s[3] = 1'b1;
                            state_nxt_s = ST_IDLE;
                        end
                    end else begin
                        state_nxt_s = ST_ERASE_SETUP;
                    end
                end
                ST_ERASE_BUSY: begin
                    // Block base has zero low bits, so OR-ing the counter is the add
                    mem_we_s = 1'b1;
                    mem_wa_s = addr_r | {{(MEM_AW-BLK_AW){1'b0}}, ecnt_r};
                    mem_wd_s = 16'hFFFF;
                    if (ecnt_r == ECNT_LAST) begin
                        ecnt_nxt_s  = {BLK_AW{1'b0}};
                        sr_nxt_s[7] = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        ecnt_nxt_s  = ecnt_r + ECNT_ONE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State, status, counters, read register and busy flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            rmode_r <= 1'b0;
            sr_r    <= 8'h80;
            pcnt_r  <= {PCW{1'b0}};
            ecnt_r  <= {BLK_AW{1'b0}};
            addr_r  <= {MEM_AW{1'b0}};
            data_r  <= 16'h0000;
            we_q_r  <= 1'b1;
            rd_q_r  <= 16'h0000;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            rmode_r <= rmode_nxt_s;
            sr_r    <= sr_nxt_s;
            pcnt_r  <= pcnt_nxt_s;
            ecnt_r  <= ecnt_nxt_s;
            addr_r  <= addr_nxt_s;
            data_r  <= data_nxt_s;
            we_q_r  <= we_s;
            rd_q_r  <= rmode_r ? {8'h00, sr_r} : mem_r[waddr_s];
            busy_r  <= (state_nxt_s == ST_PROG_BUSY) || (state_nxt_s == ST_ERASE_BUSY);
        end
    end

    // Storage array: deliberately not reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_r[mem_wa_s] <= mem_wd_s;
        end
    end
endmodule

// File: doc/flash_responder.md
FLASH_RESPONDER -- requirements
Module: flash_responder

Interface
REQ-001 SHALL have parameter MEM_AW, default 8, meaning word-address width of the internal array (2^MEM_AW 16-bit words).
REQ-002 SHALL have parameter BLK_AW, default 5, meaning erase-block word-address width (2^BLK_AW words per block), BLK_AW < MEM_AW.
REQ-003 SHALL have parameter PROG_CYCLES, default 4, meaning program busy time in clk cycles (>=1).
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port flash_addr  input  23  byte address from initiator; bit 0 ignored, word address = flash_addr[MEM_AW:1], higher bits ignored (aliasing).
REQ-007 SHALL have port flash_data  inout  16  shared data bus.
REQ-008 SHALL have port flash_ctl  input  8  {byte, ce, ce1, ce2, oe, rp, vpen, we}, bit 7 = byte, bit 0 = we; ce, oe, we, rp active-low.
REQ-009 SHALL have port busy  output  1  program/erase in progress (debug/bench observation).

Function
REQ-010 Selected = ce==0; all bus activity ignored when ce==1.
REQ-011 WE strobe: register we each cycle as we_q; a command write occurs on a cycle with selected, we_q==0, we==1; flash_data and flash_addr sampled that cycle.
REQ-012 Drive flash_data with rd_q when selected and oe==0, otherwise high-Z.
REQ-013 rd_q registered every cycle: rd_q <= (rmode==STATUS) ? {8'h00, sr} : mem[word address]; read latency one cycle after address/mode stable.
REQ-014 Status register sr[7]=ready (1 = idle), sr[5]=erase error, sr[4]=program error, sr[3]=vpen error; other bits 0.
REQ-015 FSM states: IDLE, PROG_SETUP, PROG_BUSY, ERASE_SETUP, ERASE_BUSY.
REQ-016 IDLE, write 0x00FF -> rmode=ARRAY; 0x0070 -> rmode=STATUS; 0x0050 -> clear sr[5:3]; 0x0040 or 0x0010 -> PROG_SETUP; 0x0020 -> ERASE_SETUP; any other value ignored. Upper data byte ignored in command decode.
REQ-017 PROG_SETUP, next write: latch address and data; if vpen==0 set sr[4] and sr[3], go IDLE; else go PROG_BUSY, sr[7]=0, rmode=STATUS, load counter PROG_CYCLES.
REQ-018 PROG_BUSY: decrement counter per cycle; at counter reaching 0, mem[addr] <= mem[addr] AND data (bits only cleared), sr[7]=1, go IDLE.
REQ-019 ERASE_SETUP, next write: data[7:0]==0xD0 and vpen==1 -> latch block base (word address with low BLK_AW bits zero), go ERASE_BUSY, sr[7]=0, rmode=STATUS, word counter 0; data[7:0]!=0xD0 -> set sr[5] and sr[4], go IDLE; vpen==0 -> set sr[5] and sr[3], go IDLE.
REQ-020 ERASE_BUSY: one word per cycle, mem[base+counter] <= 16'hFFFF; after word 2^BLK_AW-1 written, sr[7]=1, go IDLE; erase busy = 2^BLK_AW cycles.
REQ-021 Writes while PROG_BUSY or ERASE_BUSY ignored; reads return status (rmode forced STATUS).
REQ-022 After program/erase completion rmode stays STATUS until 0x00FF written.
REQ-023 rp==0: synchronous abort, FSM -> IDLE, rmode=ARRAY, sr=0x80; in-flight erase leaves already-written words erased, rest unchanged; aborted program writes nothing.
REQ-024 busy = 1 exactly in PROG_BUSY and ERASE_BUSY.
REQ-025 Signal byte, ce1, ce2 ignored.

Reset
REQ-026 rst_n==0 asynchronously: state=IDLE, rmode=ARRAY, sr=0x80, we_q=1, counters=0, rd_q=0, busy=0, flash_data high-Z.
REQ-027 Memory array not reset; contents undefined until erased or preloaded by bench backdoor.
REQ-028 Reset mid-program/erase aborts as REQ-023 (memory partially erased allowed).

Verification
REQ-029 Erase block at word 0x20 (0x0020, 0x00D0), poll 0x0070 -> sr reads 0x0000 for 32 cycles, then 0x0080; 0x00FF then read words 0x20..0x3F -> 0xFFFF.
REQ-030 After erase, program 0x1234 at word 0x25 -> busy high 4 cycles, status 0x0080; array read word 0x25 -> 0x1234, word 0x24 -> 0xFFFF.
REQ-031 Program 0xFF00 over 0x1234 at word 0x25 -> reads 0x1200 (AND rule).
REQ-032 Erase setup then 0x00AA confirm -> status 0x00B0, memory unchanged; 0x0050 -> status 0x0080.
REQ-033 vpen=0 during program confirm -> status 0x0098, no memory change; command writes issued during ERASE_BUSY ignored, erase completes normally.
REQ-034 rst_n pulsed low mid-erase -> busy=0 immediately, array mode, oe low reads memory, status 0x0080; oe high or ce high -> bus high-Z.
